// File: rtl/rf_wb_scheduler_pkg.sv
// Shared widths and the write-port source encoding for the register-file
// writeback scheduler.
package rf_wb_scheduler_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_BUF,
        SRC_LU
    } wr_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy bits and outstanding-op count for long-latency dispatches; produces
// the same-cycle hazard term that stalls issue.
module rf_scoreboard
    import rf_wb_scheduler_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_long,
    input  logic                  i_commit,
    input  logic [REG_ADDR_W-1:0] i_commit_addr,
    output logic                  o_hazard
);

    logic [NUM_REGS-1:1] r_busy;
    logic [CNT_W-1:0]    r_out_cnt;

    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:1] w_busy_nxt;
    logic                w_full;
    logic                w_dispatch;

    // x0 never carries a pending write
    assign w_busy     = {r_busy, 1'b0};
    assign w_full     = (r_out_cnt == CNT_W'(MAX_OUT));
    assign o_hazard   = i_id_valid && (w_busy[i_id_rs1] || w_busy[i_id_rs2] ||
                        w_busy[i_id_rd] || (i_id_long && w_full));
    assign w_dispatch = i_id_valid && i_id_long && !o_hazard;

    always_comb begin
        w_busy_nxt = r_busy;
        if (i_commit && (i_commit_addr != '0)) begin
            w_busy_nxt[i_commit_addr] = 1'b0;
        end
        if (w_dispatch && (i_id_rd != '0)) begin
            w_busy_nxt[i_id_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= '0;
            r_out_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            case ({w_dispatch, i_commit})
                2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
                2'b01:   if (r_out_cnt != '0) r_out_cnt <= r_out_cnt - 1'b1;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: WB/LU arbitration, one-entry LU result
// buffer, starvation drain request and protocol-error flag.
module rf_wb_scheduler
    import rf_wb_scheduler_pkg::*;
#(
    parameter int MAX_OUT  = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_long,
    output logic                  o_issue_stall,
    input  logic                  i_wb_valid,
    input  logic [REG_ADDR_W-1:0] i_wb_addr,
    input  logic [XLEN-1:0]       i_wb_data,
    input  logic                  i_lu_valid,
    input  logic [REG_ADDR_W-1:0] i_lu_addr,
    input  logic [XLEN-1:0]       i_lu_data,
    output logic                  o_lu_ready,
    output logic                  o_rf_we,
    output logic [REG_ADDR_W-1:0] o_rf_waddr,
    output logic [XLEN-1:0]       o_rf_wdata,
    output logic                  o_drain_req,
    output logic                  o_proto_err
);

    logic                  r_buf_valid;
    logic [REG_ADDR_W-1:0] r_buf_addr;
    logic [XLEN-1:0]       r_buf_data;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_drain_req;
    logic                  r_proto_err;

    wr_src_e               w_src;
    logic                  w_wb_wr;
    logic                  w_lu_acc;
    logic                  w_buf_load;
    logic                  w_we;
    logic                  w_commit;
    logic [REG_ADDR_W-1:0] w_commit_addr;
    logic                  w_buf_valid_nxt;
    logic [CNT_W-1:0]      w_wait_nxt;

    assign w_wb_wr    = i_wb_valid && (i_wb_addr != '0);
    assign o_lu_ready = !r_buf_valid;
    assign w_lu_acc   = i_lu_valid && o_lu_ready;
    // LU result accepted while WB owns the port is parked in the buffer
    assign w_buf_load = w_lu_acc && w_wb_wr;

    always_comb begin
        w_src = SRC_NONE;
        if (w_wb_wr) begin
            w_src = SRC_WB;
        end else if (r_buf_valid) begin
            w_src = SRC_BUF;
        end else if (w_lu_acc) begin
            w_src = SRC_LU;
        end
    end

    always_comb begin
        w_we          = 1'b0;
        w_commit      = 1'b0;
        w_commit_addr = '0;
        o_rf_waddr    = '0;
        o_rf_wdata    = '0;
        case (w_src)
            SRC_WB: begin
                w_we       = 1'b1;
                o_rf_waddr = i_wb_addr;
                o_rf_wdata = i_wb_data;
            end
            SRC_BUF: begin
                w_we          = (r_buf_addr != '0);
                w_commit      = 1'b1;
                w_commit_addr = r_buf_addr;
                o_rf_waddr    = r_buf_addr;
                o_rf_wdata    = r_buf_data;
            end
            SRC_LU: begin
                w_we          = (i_lu_addr != '0);
                w_commit      = 1'b1;
                w_commit_addr = i_lu_addr;
                o_rf_waddr    = i_lu_addr;
                o_rf_wdata    = i_lu_data;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // The regfile samples on negedge, so reset must mask the strobe at once
    assign o_rf_we = rst_n && w_we;

    always_comb begin
        w_buf_valid_nxt = r_buf_valid;
        w_wait_nxt      = r_wait_cnt;
        if (w_src == SRC_BUF) begin
            w_buf_valid_nxt = 1'b0;
            w_wait_nxt      = '0;
        end else if (w_buf_load) begin
            w_buf_valid_nxt = 1'b1;
        end else if (r_buf_valid && w_wb_wr && (r_wait_cnt != '1)) begin
            w_wait_nxt = r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_wait_cnt  <= '0;
            r_drain_req <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_buf_valid <= w_buf_valid_nxt;
            r_wait_cnt  <= w_wait_nxt;
            if (w_buf_load) begin
                r_buf_addr <= i_lu_addr;
                r_buf_data <= i_lu_data;
            end
            r_drain_req <= w_buf_valid_nxt && (w_wait_nxt >= CNT_W'(MAX_WAIT));
            r_proto_err <= r_proto_err || (i_wb_valid && r_drain_req);
        end
    end

    assign o_drain_req = r_drain_req;
    assign o_proto_err = r_proto_err;

    rf_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_id_valid    (i_id_valid),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_rd       (i_id_rd),
        .i_id_long     (i_id_long),
        .i_commit      (w_commit),
        .i_commit_addr (w_commit_addr),
        .o_hazard      (o_issue_stall)
    );

endmodule
